mdu_seq: RTL and testbench

- Iterative RV32M multiply/divide sequencer beside the EXE-stage ALU.
- Accepts one operation from EXE over a valid/ready handshake and runs a 32-step shift-add multiply or a restoring divide.
- Presents the result over a second valid/ready handshake and holds EXE stalled, through EXE's left_ready, while busy.
- Honours the pipeline flush raised by taken branches.

---
 rtl/mdu_seq_pkg.sv | 29 ++
 rtl/mdu_sign_prep.sv | 37 +++
 rtl/mdu_seq.sv | 187 ++++++++++++++++++
 tb/tb_mdu_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide sequencer.
package mdu_seq_pkg;

  localparam int MDU_OP_W  = 3;
  localparam int MDU_STEPS = 32;

  typedef enum logic [MDU_OP_W-1:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // Divide-family ops all have bit 2 set; bit 1 then separates REM from DIV.
  function automatic logic op_is_div(input logic [MDU_OP_W-1:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_sign_prep.sv
// Turns op/src1/src2 into unsigned operand magnitudes plus the sign flags
// needed to correct the unsigned result at the end of the iteration.
module mdu_sign_prep
  import mdu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [MDU_OP_W-1:0] i_op,
  input  logic [XLEN-1:0]     i_src1,
  input  logic [XLEN-1:0]     i_src2,
  output logic [XLEN-1:0]     o_mag1,
  output logic [XLEN-1:0]     o_mag2,
  output logic                o_neg_prod,
  output logic                o_neg_quot,
  output logic                o_neg_rem
);

  logic w_s1_signed;
  logic w_s2_signed;
  logic w_s1_neg;
  logic w_s2_neg;

  assign w_s1_signed = (i_op == OP_MULH) | (i_op == OP_MULHSU) |
                       (i_op == OP_DIV)  | (i_op == OP_REM);
  assign w_s2_signed = (i_op == OP_MULH) | (i_op == OP_DIV) | (i_op == OP_REM);

  assign w_s1_neg = w_s1_signed & i_src1[XLEN-1];
  assign w_s2_neg = w_s2_signed & i_src2[XLEN-1];

  assign o_mag1 = w_s1_neg ? -i_src1 : i_src1;
  assign o_mag2 = w_s2_neg ? -i_src2 : i_src2;

  assign o_neg_prod = w_s1_neg ^ w_s2_neg;
  assign o_neg_quot = w_s1_neg ^ w_s2_neg;
  assign o_neg_rem  = w_s1_neg;

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M sequencer: 32-step shift-add multiply or restoring divide,
// one op at a time, with valid/ready on both request and response sides.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [MDU_OP_W-1:0] req_op,
  input  logic [XLEN-1:0]     req_src1,
  input  logic [XLEN-1:0]     req_src2,
  input  logic                flush,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [XLEN-1:0]     resp_result,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  // Handshakes: a transfer happens on an edge where valid and ready are both
  // high; valid never waits on ready, and the payload holds while valid & ~ready.

  mdu_state_e          r_state;
  mdu_state_e          w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [MDU_OP_W-1:0] r_op;
  logic [XLEN-1:0]     r_mcand;
  logic [XLEN-1:0]     r_mplier;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_result;
  logic                r_neg_main;
  logic                r_neg_rem;

  logic [XLEN-1:0]     w_mag1;
  logic [XLEN-1:0]     w_mag2;
  logic                w_neg_prod;
  logic                w_neg_quot;
  logic                w_neg_rem;

  mdu_sign_prep #(.XLEN(XLEN)) u_sign_prep (
    .i_op       (req_op),
    .i_src1     (req_src1),
    .i_src2     (req_src2),
    .o_mag1     (w_mag1),
    .o_mag2     (w_mag2),
    .o_neg_prod (w_neg_prod),
    .o_neg_quot (w_neg_quot),
    .o_neg_rem  (w_neg_rem)
  );

  logic w_req_fire;
  logic w_last;
  logic w_in_div;
  logic w_div_zero;
  logic w_div_ovf;
  logic w_special;
  logic [XLEN-1:0] w_special_res;

  assign w_req_fire = req_valid & req_ready;
  assign w_last     = (r_cnt == CNT_W'(MDU_STEPS - 1));
  assign w_in_div   = op_is_div(req_op);
  assign w_div_zero = w_in_div & (req_src2 == '0);
  assign w_div_ovf  = ((req_op == OP_DIV) | (req_op == OP_REM)) &
                      (req_src1 == {1'b1, {(XLEN-1){1'b0}}}) & (req_src2 == '1);
  assign w_special  = w_div_zero | w_div_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = req_op[1] ? req_src1 : '1;
    end else if (w_div_ovf) begin
      w_special_res = req_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // One iteration step of each algorithm; r_mplier doubles as the dividend
  // shifting out MSB-first while quotient bits shift in at the bottom.
  logic [2*XLEN-1:0] w_addend;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_nxt;
  logic [XLEN-1:0]   w_quot_nxt;

  assign w_addend   = {{XLEN{1'b0}}, r_mcand} << r_cnt;
  assign w_acc_nxt  = r_mplier[0] ? (r_acc + w_addend) : r_acc;
  assign w_rem_sh   = {r_rem, r_mplier[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_mcand};
  assign w_ge       = ~w_diff[XLEN];
  assign w_rem_nxt  = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quot_nxt = {r_mplier[XLEN-2:0], w_ge};

  logic [2*XLEN-1:0] w_prod_fin;
  logic [XLEN-1:0]   w_quot_fin;
  logic [XLEN-1:0]   w_rem_fin;
  logic [XLEN-1:0]   w_calc_res;

  assign w_prod_fin = r_neg_main ? -w_acc_nxt : w_acc_nxt;
  assign w_quot_fin = r_neg_main ? -w_quot_nxt : w_quot_nxt;
  assign w_rem_fin  = r_neg_rem ? -w_rem_nxt : w_rem_nxt;

  always_comb begin
    w_calc_res = w_prod_fin[XLEN-1:0];
    case (r_op)
      OP_MUL:                      w_calc_res = w_prod_fin[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_calc_res = w_prod_fin[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             w_calc_res = w_quot_fin;
      default:                     w_calc_res = w_rem_fin;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_req_fire) w_state_nxt = w_special ? ST_DONE : ST_CALC;
        ST_CALC: if (w_last)     w_state_nxt = ST_DONE;
        ST_DONE: if (resp_ready) w_state_nxt = ST_IDLE;
        default:                 w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_result   <= '0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_op       <= req_op;
            r_cnt      <= '0;
            r_mcand    <= w_in_div ? w_mag2 : w_mag1;
            r_mplier   <= w_in_div ? w_mag1 : w_mag2;
            r_acc      <= '0;
            r_rem      <= '0;
            r_neg_main <= w_in_div ? w_neg_quot : w_neg_prod;
            r_neg_rem  <= w_neg_rem;
            if (w_special) r_result <= w_special_res;
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (op_is_div(r_op)) begin
            r_rem    <= w_rem_nxt;
            r_mplier <= w_quot_nxt;
          end else begin
            r_acc    <= w_acc_nxt;
            r_mplier <= r_mplier >> 1;
          end
          if (w_last) r_result <= w_calc_res;
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE) & ~flush;
  assign resp_valid  = (r_state == ST_DONE);
  assign resp_result = r_result;
  assign busy        = (r_state != ST_IDLE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed and lightly randomised bench for mdu_seq with an expected-result
// queue filled at request time and drained when a response is taken.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  mdu_seq dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .flush       (flush),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, observed hang expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && (b == 0)) return 0;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  // Presents one request and returns in the sample slot after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin step(); n++; end
    check("issue_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    exp_q.push_back(model(op, a, b));
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 100) begin step(); lat++; end
  endtask

  task automatic take_result(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, resp_result, e);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int lat;
    issue(op, a, b);
    check({tag, "_ready_low"}, 32'(req_ready), 32'd0);
    wait_resp(lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_latency(op, a, b)));
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    take_result(tag);
    step();
    check({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic seen;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_src1   = '0;
    req_src2   = '0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_result", resp_result, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    run_op("mul_7x_m3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    check("mul_7x_m3_const", model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7);
    run_op("divu_by0", 3'd5, 32'd5, 32'd0);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_by0", 3'd4, 32'h1234_5678, 32'd0);

    // Back-pressure: result must hold while the consumer stalls.
    resp_ready = 1'b0;
    issue(3'd0, 32'd3, 32'd4);
    wait_resp(lat);
    check("hold_latency", 32'(lat), 32'd32);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_result", resp_result, exp_q[0]);
      step();
    end
    check("hold_valid_end", 32'(resp_valid), 32'd1);
    resp_ready = 1'b1;
    take_result("hold");
    step();
    check("hold_release_valid", 32'(resp_valid), 32'd0);
    check("hold_release_ready", 32'(req_ready), 32'd1);

    // Flush mid-divide, with a competing request on the same cycle.
    issue(3'd4, 32'd1000, 32'd7);
    repeat (8) step();
    check("flush_busy_before", 32'(busy), 32'd1);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_src1  = 32'd2;
    req_src2  = 32'd3;
    check("flush_req_ready", 32'(req_ready), 32'd0);
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    void'(exp_q.pop_back());
    check("flush_state", 32'(dbg_state), 32'd0);
    check("flush_valid", 32'(resp_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (resp_valid || busy) seen = 1'b1;
    end
    check("flush_no_resp", 32'(seen), 32'd0);

    // Reset mid-divide.
    issue(3'd5, 32'd999, 32'd4);
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    void'(exp_q.pop_back());
    check("rst_mid_state", 32'(dbg_state), 32'd0);
    check("rst_mid_result", resp_result, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (resp_valid || busy) seen = 1'b1;
    end
    check("rst_mid_no_resp", 32'(seen), 32'd0);

    // Random operations checked against the arithmetic model.
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom();
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
      if (i == 0) rb = 32'd0;
      run_op("rand", rop, ra, rb);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
